// File: rtl/commit_sequencer.sv
// In-order commit stage: buffers one finished result per execution unit and retires
// them strictly by issue tag, driving register writeback, unit release and jump redirect.
module commit_sequencer #(
    parameter int N_ALU  = 3,
    parameter int CNT_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int UNIT_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_ALU:0]               i_unit_valid,
    input  logic [(N_ALU+1)*CNT_W-1:0]   i_unit_cnt,
    input  logic [(N_ALU+1)*REG_W-1:0]   i_unit_rd,
    input  logic [(N_ALU+1)*DATA_W-1:0]  i_unit_data,
    input  logic [N_ALU:0]               i_unit_jmp,
    input  logic [(N_ALU+1)*ADDR_W-1:0]  i_unit_target,
    output logic [N_ALU:0]               o_unit_ack,
    output logic [REG_W-1:0]             o_wreg,
    output logic [DATA_W-1:0]            o_wdata,
    output logic [UNIT_W-1:0]            o_free,
    output logic                         o_jmp_valid,
    output logic [ADDR_W-1:0]            o_jmp_target,
    output logic                         o_flush
);
    localparam int NU    = N_ALU + 1;
    localparam int SEL_W = (NU > 1) ? $clog2(NU) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Per-unit result slots
    logic              full_q [NU];
    logic              full_d [NU];
    logic [CNT_W-1:0]  cnt_q  [NU];
    logic [CNT_W-1:0]  cnt_d  [NU];
    logic [REG_W-1:0]  rd_q   [NU];
    logic [REG_W-1:0]  rd_d   [NU];
    logic [DATA_W-1:0] data_q [NU];
    logic [DATA_W-1:0] data_d [NU];
    logic              jmp_q  [NU];
    logic              jmp_d  [NU];
    logic [ADDR_W-1:0] tgt_q  [NU];
    logic [ADDR_W-1:0] tgt_d  [NU];

    // Commit candidates: the held slot, or the result being captured this very edge
    logic              cand_v    [NU];
    logic [CNT_W-1:0]  cand_cnt  [NU];
    logic [REG_W-1:0]  cand_rd   [NU];
    logic [DATA_W-1:0] cand_data [NU];
    logic              cand_jmp  [NU];
    logic [ADDR_W-1:0] cand_tgt  [NU];

    logic [CNT_W-1:0]  nxt_q, nxt_d;
    logic              hit;
    logic [SEL_W-1:0]  sel_idx;
    logic [REG_W-1:0]  c_rd;
    logic [DATA_W-1:0] c_data;
    logic              c_jmp;
    logic [ADDR_W-1:0] c_tgt;
    logic [UNIT_W-1:0] c_free;

    logic [UNIT_W-1:0] free_q, free_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              jv_q, jv_d;
    logic [ADDR_W-1:0] jt_q, jt_d;
    logic              flush_q, flush_d;

    genvar gi;
    generate
        for (gi = 0; gi < NU; gi++) begin : g_slot
            logic ack;
            assign ack             = i_unit_valid[gi] & ~full_q[gi] & ~rst;
            assign o_unit_ack[gi]  = ack;
            assign cand_v[gi]      = full_q[gi] | ack;
            assign cand_cnt[gi]    = full_q[gi] ? cnt_q[gi]  : i_unit_cnt[gi*CNT_W +: CNT_W];
            assign cand_rd[gi]     = full_q[gi] ? rd_q[gi]   : i_unit_rd[gi*REG_W +: REG_W];
            assign cand_data[gi]   = full_q[gi] ? data_q[gi] : i_unit_data[gi*DATA_W +: DATA_W];
            assign cand_jmp[gi]    = full_q[gi] ? jmp_q[gi]  : i_unit_jmp[gi];
            assign cand_tgt[gi]    = full_q[gi] ? tgt_q[gi]  : i_unit_target[gi*ADDR_W +: ADDR_W];

            always_comb begin
                full_d[gi] = full_q[gi];
                cnt_d[gi]  = cnt_q[gi];
                rd_d[gi]   = rd_q[gi];
                data_d[gi] = data_q[gi];
                jmp_d[gi]  = jmp_q[gi];
                tgt_d[gi]  = tgt_q[gi];
                if (ack) begin
                    full_d[gi] = 1'b1;
                    cnt_d[gi]  = i_unit_cnt[gi*CNT_W +: CNT_W];
                    rd_d[gi]   = i_unit_rd[gi*REG_W +: REG_W];
                    data_d[gi] = i_unit_data[gi*DATA_W +: DATA_W];
                    jmp_d[gi]  = i_unit_jmp[gi];
                    tgt_d[gi]  = i_unit_target[gi*ADDR_W +: ADDR_W];
                end
                // A committing jump squashes every slot, including one captured this edge
                if (hit && (sel_idx == SEL_W'(gi) || c_jmp)) begin
                    full_d[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    full_q[gi] <= 1'b0;
                end else begin
                    full_q[gi] <= full_d[gi];
                end
                cnt_q[gi]  <= cnt_d[gi];
                rd_q[gi]   <= rd_d[gi];
                data_q[gi] <= data_d[gi];
                jmp_q[gi]  <= jmp_d[gi];
                tgt_q[gi]  <= tgt_d[gi];
            end
        end
    endgenerate

    // Descending scan so that the lowest-index match wins
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        c_rd    = '0;
        c_data  = '0;
        c_jmp   = 1'b0;
        c_tgt   = '0;
        for (int k = NU - 1; k >= 0; k--) begin
            if (cand_v[k] && cand_cnt[k] == nxt_q) begin
                hit     = 1'b1;
                sel_idx = SEL_W'(k);
                c_rd    = cand_rd[k];
                c_data  = cand_data[k];
                c_jmp   = cand_jmp[k];
                c_tgt   = cand_tgt[k];
            end
        end
    end

    assign c_free = UNIT_W'(sel_idx) + UNIT_W'(1);

    always_comb begin
        nxt_d   = nxt_q;
        free_d  = '0;
        wreg_d  = '0;
        wdata_d = '0;
        jv_d    = 1'b0;
        jt_d    = '0;
        flush_d = 1'b0;
        if (hit) begin
            nxt_d   = (nxt_q == CNT_MAX) ? CNT_W'(1) : nxt_q + CNT_W'(1);
            free_d  = c_free;
            wreg_d  = c_rd;
            wdata_d = (c_rd == '0) ? '0 : c_data;
            jv_d    = c_jmp;
            jt_d    = c_jmp ? c_tgt : '0;
            flush_d = c_jmp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_q   <= CNT_W'(1);
            free_q  <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
            jv_q    <= 1'b0;
            jt_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            nxt_q   <= nxt_d;
            free_q  <= free_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            jv_q    <= jv_d;
            jt_q    <= jt_d;
            flush_q <= flush_d;
        end
    end

    // Outputs read as zero throughout a reset cycle, not only after it
    assign o_free       = rst ? '0 : free_q;
    assign o_wreg       = rst ? '0 : wreg_q;
    assign o_wdata      = rst ? '0 : wdata_q;
    assign o_jmp_valid  = rst ? 1'b0 : jv_q;
    assign o_jmp_target = rst ? '0 : jt_q;
    assign o_flush      = rst ? 1'b0 : flush_q;

endmodule
